// File: rtl/fc_sync_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fc_sync_pkg
//  Description : Shared definitions for the FC sync handshake: sequencer
//                state encoding, fail codes and FPGA_FC_sync_reg bit indices.
//                Also used by the timekeeper side of the handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
package fc_sync_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_WAIT_PPS   = 3'd2,
        ST_LOAD_TIME  = 3'd3,
        ST_WAIT_READY = 3'd4,
        ST_DONE       = 3'd5,
        ST_FAIL       = 3'd6
    } fc_state_t;

    // fail_code values
    localparam logic [1:0] c_fail_none  = 2'd0;
    localparam logic [1:0] c_fail_lock  = 2'd1;
    localparam logic [1:0] c_fail_pps   = 2'd2;
    localparam logic [1:0] c_fail_ready = 2'd3;

    // Bit positions inside FPGA_FC_sync_reg
    localparam int unsigned c_bit_lock_ready  = 0;
    localparam int unsigned c_bit_pps_look    = 1;
    localparam int unsigned c_bit_start_ready = 2;
    localparam int unsigned c_sync_bits       = 3;
    localparam int unsigned c_sync_reg_w      = 16;

endpackage
`default_nettype wire

// File: rtl/pps_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pps_edge_sync
//  Description : Two-flop synchronizer for the asynchronous GPS PPS followed
//                by a registered rising-edge detector. o_pps_rise is a
//                one-cycle pulse, visible 3 clock edges after the input edge.
//  Ports       : clk        - sampling clock
//                rst        - asynchronous active-high reset
//                i_pps      - asynchronous PPS input
//                o_pps_rise - one-cycle rising-edge pulse (clk domain)
//  Revision    : 1.0 - initial release
// ============================================================================
module pps_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_pps,
    output logic o_pps_rise
);

    logic r_meta_q, r_sync_q, r_prev_q, r_rise_q;
    logic w_meta_d, w_sync_d, w_prev_d, w_rise_d;

    always_comb begin
        w_meta_d = i_pps;
        w_sync_d = r_meta_q;
        w_prev_d = r_sync_q;
        w_rise_d = r_sync_q & ~r_prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta_q <= 1'b0;
            r_sync_q <= 1'b0;
            r_prev_q <= 1'b0;
            r_rise_q <= 1'b0;
        end else begin
            r_meta_q <= w_meta_d;
            r_sync_q <= w_sync_d;
            r_prev_q <= w_prev_d;
            r_rise_q <= w_rise_d;
        end
    end

    assign o_pps_rise = r_rise_q;

endmodule
`default_nettype wire

// File: rtl/fc_sync_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fc_sync_sequencer
//  Description : Sequences the FPGA / flight-computer time sync handshake:
//                wait for GPS lock, latch GPS time on the next PPS, publish
//                start time = GPS time + TIME_STEP, then wait for the
//                timekeeper ready flag. Each wait state has a timeout.
//  Ports       : clk210_p            - clock
//                reset_p             - asynchronous active-high reset
//                start_p             - start pulse
//                gps_lock_p          - GPS lock status
//                gps_time_p          - GPS time of most recent PPS
//                pps_gps_p           - asynchronous GPS PPS
//                timekeeper_ready_p  - timekeeper ready flag
//                FPGA_FC_sync_reg_p  - [0] lock_ready [1] pps_look
//                                      [2] start_time_ready
//                FC_GPS_start_time_p - start time for the timekeeper
//                busy_p/done_p/fail_p, fail_code_p - status
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_sync_sequencer
    import fc_sync_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 315000000,
    parameter logic [63:0] TIME_STEP      = 64'd1000000000
) (
    input  logic        clk210_p,
    input  logic        reset_p,
    input  logic        start_p,
    input  logic        gps_lock_p,
    input  logic [63:0] gps_time_p,
    input  logic        pps_gps_p,
    input  logic        timekeeper_ready_p,
    output logic [15:0] FPGA_FC_sync_reg_p,
    output logic [63:0] FC_GPS_start_time_p,
    output logic        busy_p,
    output logic        done_p,
    output logic        fail_p,
    output logic [1:0]  fail_code_p
);

    localparam int unsigned c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    fc_state_t                r_state_q, w_state_d;
    logic [c_cnt_w-1:0]       r_cnt_q, w_cnt_d;
    logic [c_sync_bits-1:0]   r_sync_q, w_sync_d;
    logic [1:0]               r_fail_code_q, w_fail_code_d;
    logic [63:0]              r_start_time_q, w_start_time_d;
    logic                     w_pps_rise;
    logic                     w_timeout;
    logic                     w_in_wait;

    pps_edge_sync u_pps_edge_sync (
        .clk        (clk210_p),
        .rst        (reset_p),
        .i_pps      (pps_gps_p),
        .o_pps_rise (w_pps_rise)
    );

    assign w_timeout = (r_cnt_q == c_cnt_last);
    assign w_in_wait = (r_state_q == ST_WAIT_LOCK) || (r_state_q == ST_WAIT_PPS) ||
                       (r_state_q == ST_WAIT_READY);

    always_comb begin
        w_state_d      = r_state_q;
        w_sync_d       = r_sync_q;
        w_fail_code_d  = r_fail_code_q;
        w_start_time_d = r_start_time_q;

        // Exit conditions are tested before the timeout so they win a tie.
        case (r_state_q)
            ST_IDLE: begin
                if (start_p) w_state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (gps_lock_p) begin
                    w_state_d                   = ST_WAIT_PPS;
                    w_sync_d[c_bit_lock_ready]  = 1'b1;
                    w_sync_d[c_bit_pps_look]    = 1'b1;
                end else if (w_timeout) begin
                    w_state_d     = ST_FAIL;
                    w_sync_d      = '0;
                    w_fail_code_d = c_fail_lock;
                end
            end
            ST_WAIT_PPS: begin
                if (!gps_lock_p) begin
                    w_state_d     = ST_FAIL;
                    w_sync_d      = '0;
                    w_fail_code_d = c_fail_lock;
                end else if (w_pps_rise) begin
                    // The start time is formed on the latch edge so it is
                    // already stable for the whole LOAD_TIME cycle, one cycle
                    // ahead of start_time_ready.
                    w_state_d                = ST_LOAD_TIME;
                    w_start_time_d           = gps_time_p + TIME_STEP;
                    w_sync_d[c_bit_pps_look] = 1'b0;
                end else if (w_timeout) begin
                    w_state_d     = ST_FAIL;
                    w_sync_d      = '0;
                    w_fail_code_d = c_fail_pps;
                end
            end
            ST_LOAD_TIME: begin
                w_state_d                   = ST_WAIT_READY;
                w_sync_d[c_bit_start_ready] = 1'b1;
            end
            ST_WAIT_READY: begin
                if (!gps_lock_p) begin
                    w_state_d     = ST_FAIL;
                    w_sync_d      = '0;
                    w_fail_code_d = c_fail_lock;
                end else if (timekeeper_ready_p) begin
                    w_state_d = ST_DONE;
                end else if (w_timeout) begin
                    w_state_d     = ST_FAIL;
                    w_sync_d      = '0;
                    w_fail_code_d = c_fail_ready;
                end
            end
            ST_DONE, ST_FAIL: begin
                if (start_p) begin
                    w_state_d     = ST_WAIT_LOCK;
                    w_sync_d      = '0;
                    w_fail_code_d = c_fail_none;
                end
            end
            default: begin
                w_state_d     = ST_IDLE;
                w_sync_d      = '0;
                w_fail_code_d = c_fail_none;
            end
        endcase

        // Counter restarts on every state entry.
        if (w_state_d != r_state_q) begin
            w_cnt_d = '0;
        end else if (w_in_wait) begin
            w_cnt_d = r_cnt_q + c_cnt_one;
        end else begin
            w_cnt_d = '0;
        end
    end

    always_ff @(posedge clk210_p or posedge reset_p) begin
        if (reset_p) begin
            r_state_q      <= ST_IDLE;
            r_cnt_q        <= '0;
            r_sync_q       <= '0;
            r_fail_code_q  <= c_fail_none;
            r_start_time_q <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_sync_q       <= w_sync_d;
            r_fail_code_q  <= w_fail_code_d;
            r_start_time_q <= w_start_time_d;
        end
    end

    assign FPGA_FC_sync_reg_p  = {{(c_sync_reg_w - c_sync_bits){1'b0}}, r_sync_q};
    assign FC_GPS_start_time_p = r_start_time_q;
    assign busy_p              = (r_state_q != ST_IDLE) && (r_state_q != ST_DONE) &&
                                 (r_state_q != ST_FAIL);
    assign done_p              = (r_state_q == ST_DONE);
    assign fail_p              = (r_state_q == ST_FAIL);
    assign fail_code_p         = r_fail_code_q;

endmodule
`default_nettype wire

// File: tb/tb_fc_sync_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc_sync_sequencer
//  Description : Directed self-checking bench for fc_sync_sequencer with
//                TIMEOUT_CYCLES=100, TIME_STEP=1. Inputs change 1 time unit
//                after the rising edge; outputs are sampled at that point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_sync_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        lock;
    logic [63:0] gps_time;
    logic        pps;
    logic        ready;
    logic [15:0] sync_reg;
    logic [63:0] start_time;
    logic        busy;
    logic        done;
    logic        fail;
    logic [1:0]  code;

    int errors;
    int checks;

    fc_sync_sequencer #(
        .TIMEOUT_CYCLES (100),
        .TIME_STEP      (64'd1)
    ) dut (
        .clk210_p            (clk),
        .reset_p             (rst),
        .start_p             (start),
        .gps_lock_p          (lock),
        .gps_time_p          (gps_time),
        .pps_gps_p           (pps),
        .timekeeper_ready_p  (ready),
        .FPGA_FC_sync_reg_p  (sync_reg),
        .FC_GPS_start_time_p (start_time),
        .busy_p              (busy),
        .done_p              (done),
        .fail_p              (fail),
        .fail_code_p         (code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive PPS high long enough for the synchronized edge to reach the FSM
    // (3 edges of latency plus the transition edge), then drop it.
    task automatic pps_pulse;
        pps = 1'b1;
        tick(4);
        pps = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; lock = 1'b0; gps_time = '0; pps = 1'b0; ready = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        checks++; if (sync_reg !== 16'h0000) begin errors++; $display("FAIL reset_sync: got %h want %h", sync_reg, 16'h0000); end
        checks++; if (start_time !== 64'h0) begin errors++; $display("FAIL reset_start_time: got %h want %h", start_time, 64'h0); end
        checks++; if ({busy, done, fail, code} !== 5'b0) begin errors++; $display("FAIL reset_status: got %b want %b", {busy, done, fail, code}, 5'b0); end
    endtask

    task automatic test_happy_path;
        lock = 1'b1; gps_time = 64'h10;
        start = 1'b1; tick(1); start = 1'b0;                 // WAIT_LOCK
        checks++; if ({busy, sync_reg} !== {1'b1, 16'h0000}) begin errors++; $display("FAIL happy_wait_lock: got %b/%h want 1/0000", busy, sync_reg); end
        tick(1);                                             // WAIT_PPS
        checks++; if (sync_reg !== 16'h0003) begin errors++; $display("FAIL happy_lock_bits: got %h want %h", sync_reg, 16'h0003); end
        pps = 1'b1; tick(3);                                 // rise just visible
        checks++; if (sync_reg !== 16'h0003) begin errors++; $display("FAIL happy_pps_latency: got %h want %h", sync_reg, 16'h0003); end
        tick(1); pps = 1'b0;                                 // LOAD_TIME
        checks++; if (start_time !== 64'h11) begin errors++; $display("FAIL happy_start_time: got %h want %h", start_time, 64'h11); end
        checks++; if (sync_reg !== 16'h0001) begin errors++; $display("FAIL happy_load_bits: got %h want %h", sync_reg, 16'h0001); end
        tick(1);                                             // WAIT_READY
        checks++; if (sync_reg !== 16'h0005) begin errors++; $display("FAIL happy_ready_bits: got %h want %h", sync_reg, 16'h0005); end
        tick(5);
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL happy_waiting: got %b want %b", {busy, done}, 2'b10); end
        ready = 1'b1; tick(1); ready = 1'b0;                 // DONE
        checks++; if ({busy, done, fail} !== 3'b010) begin errors++; $display("FAIL happy_done: got %b want %b", {busy, done, fail}, 3'b010); end
        tick(2);
        checks++; if ({done, sync_reg, start_time} !== {1'b1, 16'h0005, 64'h11}) begin errors++; $display("FAIL happy_done_hold: got %b/%h/%h want 1/0005/11", done, sync_reg, start_time); end
    endtask

    task automatic test_wrap;
        gps_time = 64'hFFFF_FFFF_FFFF_FFFF;
        start = 1'b1; tick(1); start = 1'b0;                 // DONE -> WAIT_LOCK
        checks++; if ({done, sync_reg} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL restart_clear: got %b/%h want 0/0000", done, sync_reg); end
        tick(1);                                             // WAIT_PPS
        pps_pulse();                                         // LOAD_TIME
        checks++; if (start_time !== 64'h0) begin errors++; $display("FAIL wrap_start_time: got %h want %h", start_time, 64'h0); end
        tick(1);
        ready = 1'b1; tick(1); ready = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b want 1", done); end
    endtask

    task automatic test_timeout_lock;
        lock = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;                 // WAIT_LOCK cycle 1
        tick(99);                                            // cycle 100, count 99
        checks++; if ({busy, fail} !== 2'b10) begin errors++; $display("FAIL to_lock_early: got %b want %b", {busy, fail}, 2'b10); end
        tick(1);
        checks++; if ({fail, code, sync_reg} !== {1'b1, 2'd1, 16'h0000}) begin errors++; $display("FAIL to_lock: got %b/%0d/%h want 1/1/0000", fail, code, sync_reg); end
    endtask

    task automatic test_timeout_pps;
        lock = 1'b1;
        start = 1'b1; tick(1); start = 1'b0;
        checks++; if ({fail, code} !== 3'b000) begin errors++; $display("FAIL restart_from_fail: got %b/%0d want 0/0", fail, code); end
        tick(1);                                             // WAIT_PPS cycle 1
        tick(99);
        checks++; if ({busy, sync_reg} !== {1'b1, 16'h0003}) begin errors++; $display("FAIL to_pps_early: got %b/%h want 1/0003", busy, sync_reg); end
        tick(1);
        checks++; if ({fail, code, sync_reg} !== {1'b1, 2'd2, 16'h0000}) begin errors++; $display("FAIL to_pps: got %b/%0d/%h want 1/2/0000", fail, code, sync_reg); end
    endtask

    task automatic test_timeout_ready;
        gps_time = 64'h40;
        start = 1'b1; tick(1); start = 1'b0;
        tick(1);
        pps_pulse();                                         // LOAD_TIME
        tick(1);                                             // WAIT_READY cycle 1
        tick(99);
        checks++; if ({busy, sync_reg} !== {1'b1, 16'h0005}) begin errors++; $display("FAIL to_ready_early: got %b/%h want 1/0005", busy, sync_reg); end
        tick(1);
        checks++; if ({fail, code, sync_reg} !== {1'b1, 2'd3, 16'h0000}) begin errors++; $display("FAIL to_ready: got %b/%0d/%h want 1/3/0000", fail, code, sync_reg); end
    endtask

    task automatic test_pps_boundary;
        gps_time = 64'h1234;
        start = 1'b1; tick(1); start = 1'b0;
        tick(1);                                             // WAIT_PPS cycle 1
        tick(96);                                            // cycle 97
        pps = 1'b1;
        tick(3);                                             // cycle 100, rise visible
        checks++; if ({busy, fail} !== 2'b10) begin errors++; $display("FAIL boundary_before: got %b want %b", {busy, fail}, 2'b10); end
        tick(1); pps = 1'b0;
        checks++; if ({busy, fail, sync_reg} !== {2'b10, 16'h0001}) begin errors++; $display("FAIL boundary_load: got %b/%b/%h want 1/0/0001", busy, fail, sync_reg); end
        checks++; if (start_time !== 64'h1235) begin errors++; $display("FAIL boundary_time: got %h want %h", start_time, 64'h1235); end
    endtask

    task automatic test_reset_mid;
        tick(1);                                             // WAIT_READY
        checks++; if (sync_reg !== 16'h0005) begin errors++; $display("FAIL mid_pre: got %h want %h", sync_reg, 16'h0005); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({busy, sync_reg, start_time} !== {1'b0, 16'h0000, 64'h0}) begin errors++; $display("FAIL mid_async: got %b/%h/%h want 0/0000/0", busy, sync_reg, start_time); end
        tick(1);
        rst = 1'b0;
        tick(1);
        checks++; if ({busy, done, fail, sync_reg} !== {3'b000, 16'h0000}) begin errors++; $display("FAIL mid_idle: got %b/%h want 000/0000", {busy, done, fail}, sync_reg); end
    endtask

    task automatic test_lock_lost;
        lock = 1'b1; gps_time = 64'h20;
        start = 1'b1; tick(1); start = 1'b0;
        tick(1);                                             // WAIT_PPS
        start = 1'b1; tick(1); start = 1'b0;                 // ignored here
        checks++; if ({busy, sync_reg} !== {1'b1, 16'h0003}) begin errors++; $display("FAIL start_ignored: got %b/%h want 1/0003", busy, sync_reg); end
        lock = 1'b0; tick(1);
        checks++; if ({fail, code, sync_reg} !== {1'b1, 2'd1, 16'h0000}) begin errors++; $display("FAIL lock_lost: got %b/%0d/%h want 1/1/0000", fail, code, sync_reg); end
        lock = 1'b1;
        start = 1'b1; tick(1); start = 1'b0;
        checks++; if ({busy, fail, code} !== 4'b1000) begin errors++; $display("FAIL relaunch: got %b want %b", {busy, fail, code}, 4'b1000); end
        tick(1);
        pps_pulse();
        checks++; if (start_time !== 64'h21) begin errors++; $display("FAIL relaunch_time: got %h want %h", start_time, 64'h21); end
        tick(1);                                             // WAIT_READY
        gps_time = 64'h99;
        pps_pulse();                                         // must be ignored
        checks++; if ({busy, sync_reg, start_time} !== {1'b1, 16'h0005, 64'h21}) begin errors++; $display("FAIL pps_ignored: got %b/%h/%h want 1/0005/21", busy, sync_reg, start_time); end
        ready = 1'b1; tick(1); ready = 1'b0;
        checks++; if ({done, sync_reg} !== {1'b1, 16'h0005}) begin errors++; $display("FAIL relaunch_done: got %b/%h want 1/0005", done, sync_reg); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_happy_path();
        test_wrap();
        test_timeout_lock();
        test_timeout_pps();
        test_timeout_ready();
        test_pps_boundary();
        test_reset_mid();
        test_lock_lost();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fc_sync_sequencer.md
FC_SYNC_SEQUENCER -- requirements
Module: fc_sync_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 315000000 (1.5 s at 210 MHz), the per-state wait limit.
REQ-002 SHALL have parameter TIME_STEP, default 64'd1000000000, added to the latched GPS time to form the start time.
REQ-003 SHALL have port clk210_p, input, 1 bit, the single clock; the block has one clock.
REQ-004 SHALL have port reset_p, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port start_p, input, 1 bit, a one-cycle pulse that starts a sync sequence.
REQ-006 SHALL have port gps_lock_p, input, 1 bit, high when the GPS reports lock.
REQ-007 SHALL have port gps_time_p, input, 64 bits, GPS time of the most recent PPS.
REQ-008 SHALL have port pps_gps_p, input, 1 bit, the asynchronous GPS PPS.
REQ-009 SHALL have port timekeeper_ready_p, input, 1 bit, the timekeeper ready flag.
REQ-010 SHALL have port FPGA_FC_sync_reg_p, output, 16 bits: [0] lock_ready, [1] pps_look, [2] start_time_ready, [15:3] always 0.
REQ-011 SHALL have port FC_GPS_start_time_p, output, 64 bits, the start time handed to the timekeeper.
REQ-012 SHALL have port busy_p, output, 1 bit, high in every state except IDLE, DONE and FAIL.
REQ-013 SHALL have port done_p, output, 1 bit, high in DONE.
REQ-014 SHALL have port fail_p, output, 1 bit, high in FAIL.
REQ-015 SHALL have port fail_code_p, output, 2 bits: 1 = lock timeout, 2 = PPS timeout, 3 = ready timeout.

Function
REQ-016 SHALL pass pps_gps_p through a 2-FF synchronizer and rising-edge detect it, giving pps_rise; pps_rise is 3 cycles after the input edge.
REQ-017 SHALL use these states: IDLE, WAIT_LOCK, WAIT_PPS, LOAD_TIME, WAIT_READY, DONE, FAIL.
REQ-018 IDLE -> WAIT_LOCK on start_p; start_p SHALL be ignored in all other states except DONE and FAIL.
REQ-019 DONE or FAIL -> WAIT_LOCK on start_p; on that transition all sync bits and fail_code_p SHALL be cleared.
REQ-020 WAIT_LOCK -> WAIT_PPS when gps_lock_p is high; the same edge SHALL set bit0 and bit1.
REQ-021 WAIT_PPS: on pps_rise, SHALL latch gps_time_p, clear bit1 and go to LOAD_TIME.
REQ-022 LOAD_TIME (exactly 1 cycle): FC_GPS_start_time_p SHALL become latched time + TIME_STEP, modulo 2^64 (wrap, no saturation); the next state is WAIT_READY.
REQ-023 bit2 SHALL assert on the first WAIT_READY cycle, one cycle after FC_GPS_start_time_p is stable, so the data is valid before the ready flag.
REQ-024 WAIT_READY -> DONE when timekeeper_ready_p is high; bits 0 and 2 SHALL be held in DONE.
REQ-025 Timeout counter SHALL clear on every state entry and increment each cycle in WAIT_LOCK, WAIT_PPS and WAIT_READY.
REQ-026 When the counter reaches TIMEOUT_CYCLES-1 without the exit condition, the block SHALL go to FAIL, clear all sync bits and set fail_code_p.
REQ-027 If the exit condition and the timeout occur in the same cycle, the exit condition SHALL win.
REQ-028 If gps_lock_p falls in WAIT_PPS or WAIT_READY, the block SHALL go to FAIL with fail_code_p 1.
REQ-029 A pps_rise seen outside WAIT_PPS SHALL be ignored.
REQ-030 The counter SHALL be $clog2(TIMEOUT_CYCLES) bits wide.

Reset
REQ-031 reset_p SHALL asynchronously force IDLE, with all outputs, the counter, the latched time and the synchronizer cleared to 0.
REQ-032 A reset asserted mid-sequence SHALL drop every sync bit in the same cycle; no partial handshake survives.

Structure
REQ-033 The state encoding, fail codes and sync-bit indices (0/1/2) SHALL live in shared package fc_sync_pkg, which the timekeeper also uses.
REQ-034 The synchronizer plus edge detect SHALL be sub-module pps_edge_sync.

Verification (TIMEOUT_CYCLES=100, TIME_STEP=1)
REQ-035 Happy path: start, lock high, PPS with gps_time 0x10, ready 5 cycles later -> start_time 0x11, bit2 one cycle after the time is stable, done_p high.
REQ-036 Wrap: gps_time 0xFFFF_FFFF_FFFF_FFFF -> FC_GPS_start_time_p = 0.
REQ-037 Timeouts: no lock -> fail_code 1 at cycle 100; no PPS -> fail_code 2; no ready -> fail_code 3; sync bits 0 in every case.
REQ-038 Boundary: PPS arrives exactly on timeout cycle 99 -> LOAD_TIME, not FAIL.
REQ-039 Reset asserted in WAIT_READY -> FPGA_FC_sync_reg_p = 0 asynchronously, next state IDLE.
REQ-040 Lock lost in WAIT_PPS -> FAIL with fail_code 1; a later start_p restarts the sequence cleanly.
